// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined subtractor: saturation selector and its decode.
// The selector keeps the policy width-independent; the top maps it onto WIDTH-bit constants.
package sub_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_ZERO = 2'd1,
        SAT_MIN  = 2'd2,
        SAT_MAX  = 2'd3
    } sat_sel_t;

    localparam int AUX_W = 2;

    function automatic sat_sel_t sat_value(
        input bit   is_signed,
        input logic a_msb,
        input logic borrow,
        input logic ovf
    );
        sat_sel_t sel;
        sel = SAT_NONE;
        if (!is_signed) begin
            if (borrow) sel = SAT_ZERO;
        end else if (ovf) begin
            // overflow direction follows the minuend's sign
            sel = a_msb ? SAT_MIN : SAT_MAX;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sub_slice_stage.sv
// One pipeline stage: subtracts the S-bit slice at offset LO and registers the beat.
// The register load value for the result is supplied by the parent so the last stage can saturate.
module sub_slice_stage
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int S     = 8,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic             dn_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_res,
    input  logic             up_borrow,
    input  logic             up_sat,
    output logic [WIDTH-1:0] raw_res,
    output logic             raw_borrow,
    input  logic [WIDTH-1:0] ld_res,
    input  logic [AUX_W-1:0] ld_aux,
    output logic             valid,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic [WIDTH-1:0] q_res,
    output logic             q_borrow,
    output logic             q_sat,
    output logic [AUX_W-1:0] q_aux
);

    logic [S:0] slice;
    logic       load;

    always_comb begin
        slice   = {1'b0, up_a[LO +: S]} - {1'b0, up_b[LO +: S]} - {{S{1'b0}}, up_borrow};
        raw_res = up_res;
        raw_res[LO +: S] = slice[S-1:0];
        raw_borrow = slice[S];
    end

    assign up_ready = !valid || dn_ready;
    assign load     = up_valid && up_ready;

    // data only moves on a load, so a stalled beat stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            q_a      <= '0;
            q_b      <= '0;
            q_res    <= '0;
            q_borrow <= 1'b0;
            q_sat    <= 1'b0;
            q_aux    <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            q_a      <= up_a;
            q_b      <= up_b;
            q_res    <= ld_res;
            q_borrow <= raw_borrow;
            q_sat    <= up_sat;
            q_aux    <= ld_aux;
        end else if (dn_ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// Streaming WIDTH-bit a - b - borrow_in, one S-bit slice per stage with a registered borrow ripple.
// Saturation, overflow and zero detection are folded into the last stage before its register.
module pipelined_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);

    localparam int S = (STAGES > 0) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("pipelined_subtractor: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    // index k is the input side of stage k; index k+1 is its registered output
    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] qa   [STAGES+1];
    logic [WIDTH-1:0] qb   [STAGES+1];
    logic [WIDTH-1:0] qres [STAGES+1];
    logic [STAGES:0]  qbor;
    logic [STAGES:0]  qsat;
    logic [AUX_W-1:0] qaux [STAGES];

    assign vld[0]      = in_valid;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign qa[0]       = a;
    assign qb[0]       = b;
    assign qres[0]     = '0;
    assign qbor[0]     = borrow_in;
    assign qsat[0]     = sat_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] raw_res;
        logic             raw_borrow;
        logic [WIDTH-1:0] ld_res;
        logic [AUX_W-1:0] ld_aux;

        sub_slice_stage #(
            .WIDTH (WIDTH),
            .S     (S),
            .LO    (k * S)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (vld[k]),
            .up_ready   (rdy[k]),
            .dn_ready   (rdy[k+1]),
            .up_a       (qa[k]),
            .up_b       (qb[k]),
            .up_res     (qres[k]),
            .up_borrow  (qbor[k]),
            .up_sat     (qsat[k]),
            .raw_res    (raw_res),
            .raw_borrow (raw_borrow),
            .ld_res     (ld_res),
            .ld_aux     (ld_aux),
            .valid      (vld[k+1]),
            .q_a        (qa[k+1]),
            .q_b        (qb[k+1]),
            .q_res      (qres[k+1]),
            .q_borrow   (qbor[k+1]),
            .q_sat      (qsat[k+1]),
            .q_aux      (qaux[k])
        );

        if (k == STAGES - 1) begin : g_last
            logic     ovf_raw;
            sat_sel_t sel;

            always_comb begin
                ovf_raw = (qa[k][WIDTH-1] ^ qb[k][WIDTH-1]) &
                          (raw_res[WIDTH-1] ^ qa[k][WIDTH-1]);
                sel = SAT_NONE;
                if (qsat[k]) sel = sat_value(SIGNED, qa[k][WIDTH-1], raw_borrow, ovf_raw);
                case (sel)
                    SAT_ZERO: ld_res = '0;
                    SAT_MIN:  ld_res = {1'b1, {(WIDTH-1){1'b0}}};
                    SAT_MAX:  ld_res = {1'b0, {(WIDTH-1){1'b1}}};
                    default:  ld_res = raw_res;
                endcase
                ld_aux = {ovf_raw, (ld_res == '0)};
            end
        end else begin : g_mid
            logic unused_aux;
            assign ld_res     = raw_res;
            assign ld_aux     = '0;
            assign unused_aux = ^qaux[k];
        end
    end

    logic unused_tail;
    assign unused_tail = ^{qa[STAGES], qb[STAGES], qsat[STAGES]};

    assign out_valid  = vld[STAGES];
    assign diff       = qres[STAGES];
    assign borrow_out = qbor[STAGES];
    assign ovf        = qaux[STAGES-1][1];
    assign zero       = qaux[STAGES-1][0];

endmodule
